// File: rtl/prog_loader.sv
// prog_loader: assembles little-endian program bytes into words, writes them to instruction memory, holds the core in reset until loaded
module prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [ADDR_WIDTH:0]   WORD_COUNT,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  output logic [ADDR_WIDTH-1:0] ADDR_W,
  output logic                  ENABLE_W,
  output logic [SIZE-1:0]       Q_W,
  output logic                  CPU_RESET_N,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR
);
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
  localparam logic [ADDR_WIDTH:0] MAX_WC = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t state, next;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH:0] count;
  logic [1:0] byte_idx;
  logic [23:0] low_bytes;
  logic idle_or_done, accept, reject, take, last_byte, last_word;
  assign idle_or_done = state == S_IDLE || state == S_DONE;
  assign accept = START && idle_or_done && WORD_COUNT <= MAX_WC;
  assign reject = START && idle_or_done && WORD_COUNT > MAX_WC;
  assign take = state == S_RECV && BYTE_VALID;
  assign last_byte = take && byte_idx == 2'd3;
  assign last_word = {1'b0, word_idx} == count - 1'b1;
  // state register
  always_ff @(posedge CLK) state <= RESET ? S_IDLE : next;
  // next-state: a zero-length load completes immediately, otherwise receive/write each word in turn
  always_comb begin
    next = accept ? (WORD_COUNT == '0 ? S_DONE : S_RECV)
         : last_byte ? S_WRITE
         : state == S_WRITE ? (last_word ? S_DONE : S_RECV)
         : state;
  end
  // state-decoded outputs
  always_comb begin
    BYTE_READY = state == S_RECV;
    ENABLE_W = state == S_WRITE;
    BUSY = state == S_RECV || state == S_WRITE;
    DONE = state == S_DONE;
  end
  // indices, byte assembly, write address/data latch, sticky error and registered core reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      word_idx <= '0;
      count <= '0;
      byte_idx <= '0;
      low_bytes <= '0;
      ADDR_W <= '0;
      Q_W <= '0;
      ERROR <= 1'b0;
      CPU_RESET_N <= 1'b0;
    end else begin
      if (accept) begin
        count <= WORD_COUNT;
        word_idx <= '0;
        byte_idx <= '0;
        ERROR <= 1'b0;
      end
      if (reject) ERROR <= 1'b1;
      if (take) begin
        low_bytes <= {BYTE_IN, low_bytes[23:8]};
        byte_idx <= byte_idx + 1'b1;
      end
      if (last_byte) begin
        Q_W <= {BYTE_IN, low_bytes};
        ADDR_W <= word_idx;
      end
      if (state == S_WRITE && !last_word) word_idx <= word_idx + 1'b1;
      CPU_RESET_N <= next == S_DONE;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of byte assembly, write sequencing, start handling and reset abort
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [10:0] word_count = '0;
  logic [7:0] byte_in = '0;
  logic byte_valid = 1'b0;
  logic byte_ready, enable_w, cpu_reset_n, busy, done, error;
  logic [9:0] addr_w;
  logic [31:0] q_w;
  int total = 0;
  int passed = 0;
  int nwr = 0;
  int cyc = 0;
  int rdy_in_write = 0;
  logic [31:0] wa [2048];
  logic [31:0] wd [2048];
  prog_loader dut (
    .CLK(clk), .RESET(rst), .START(start), .WORD_COUNT(word_count),
    .BYTE_IN(byte_in), .BYTE_VALID(byte_valid), .BYTE_READY(byte_ready),
    .ADDR_W(addr_w), .ENABLE_W(enable_w), .Q_W(q_w), .CPU_RESET_N(cpu_reset_n),
    .BUSY(busy), .DONE(done), .ERROR(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (enable_w) begin
    if (nwr < 2048) begin
      wa[nwr] = 32'(addr_w);
      wd[nwr] = q_w;
    end
    nwr++;
    if (byte_ready) rdy_in_write++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_load(input logic [10:0] wc);
    start = 1'b1;
    word_count = wc;
    step();
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) step();
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      step();
      n++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 0, 1);
    else step();
    byte_valid = 1'b0;
  endtask
  task automatic load_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8], gap);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    chk("done_reached", {31'b0, done}, 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, {byte_ready, enable_w, cpu_reset_n, busy, done, error}, 0);
    chk({tag, "_addr"}, 32'(addr_w), 0);
    chk({tag, "_q"}, q_w, 0);
  endtask
  initial begin
    int c0, bad;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");
    // two-word load with continuous bytes
    start_load(11'd2);
    c0 = cyc;
    chk("recv_entry", {busy, byte_ready, cpu_reset_n, done}, 4'b1100);
    load_word(32'h00000013, 0);
    load_word(32'h00100093, 0);
    wait_done();
    chk("cont_cycles", cyc - c0, 10);
    chk("cont_nwr", nwr, 2);
    chk("cont_a0", wa[0], 0);
    chk("cont_d0", wd[0], 32'h00000013);
    chk("cont_a1", wa[1], 1);
    chk("cont_d1", wd[1], 32'h00100093);
    chk("cont_done_outs", {busy, cpu_reset_n, byte_ready, enable_w}, 4'b0100);
    // same load with three idle cycles before every byte
    nwr = 0;
    start_load(11'd2);
    load_word(32'h00000013, 3);
    load_word(32'h00100093, 3);
    wait_done();
    chk("gap_nwr", nwr, 2);
    chk("gap_d0", wd[0], 32'h00000013);
    chk("gap_a1", wa[1], 1);
    chk("gap_d1", wd[1], 32'h00100093);
    chk("rdy_in_write", rdy_in_write, 0);
    // rejected start in IDLE, zero-length load, rejected start in DONE
    rst = 1'b1;
    step();
    rst = 1'b0;
    nwr = 0;
    start_load(11'd1025);
    chk("rej_idle", {error, done, cpu_reset_n, busy}, 4'b1000);
    step();
    chk("rej_idle_hold", {error, busy, byte_ready}, 3'b100);
    start_load(11'd0);
    chk("zero_done", {done, cpu_reset_n, busy, error}, 4'b1100);
    step();
    chk("zero_nwr", nwr, 0);
    start_load(11'd1025);
    chk("rej_done", {error, done, cpu_reset_n, busy}, 4'b1110);
    // reset after two bytes of word 1
    start_load(11'd2);
    chk("err_cleared", {31'b0, error}, 0);
    load_word(32'h11223344, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("abort");
    repeat (6) step();
    chk("abort_nwr", nwr, 1);
    nwr = 0;
    start_load(11'd1);
    load_word(32'hDDCCBBAA, 0);
    wait_done();
    chk("reload_nwr", nwr, 1);
    chk("reload_a0", wa[0], 0);
    chk("reload_d0", wd[0], 32'hDDCCBBAA);
    // START pulsed during RECV is ignored
    nwr = 0;
    start_load(11'd2);
    send(8'h01, 0);
    start_load(11'd1);
    chk("ign_busy", {busy, done}, 2'b10);
    send(8'h02, 0);
    send(8'h03, 0);
    send(8'h04, 0);
    load_word(32'hCAFEF00D, 0);
    wait_done();
    chk("ign_nwr", nwr, 2);
    chk("ign_d0", wd[0], 32'h04030201);
    chk("ign_d1", wd[1], 32'hCAFEF00D);
    // restart from DONE
    nwr = 0;
    start_load(11'd1);
    chk("restart", {done, cpu_reset_n, busy}, 3'b001);
    load_word(32'h89ABCDEF, 1);
    wait_done();
    chk("restart_nwr", nwr, 1);
    chk("restart_d0", wd[0], 32'h89ABCDEF);
    // full-depth load: no wrap, no extra write
    nwr = 0;
    start_load(11'd1024);
    for (int i = 0; i < 1024; i++) load_word(32'(i) * 32'h01010101 + 32'h1000, 0);
    wait_done();
    repeat (3) step();
    chk("full_nwr", nwr, 1024);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (wa[i] != 32'(i) || wd[i] != 32'(i) * 32'h01010101 + 32'h1000) bad++;
    chk("full_seq", bad, 0);
    chk("full_last_a", wa[1023], 1023);
    chk("full_cpu_rst", {31'b0, cpu_reset_n}, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of instruction memory.
REQ-002 SHALL have parameter SIZE, default 32, instruction word width; only 32 is supported.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port START  input  1  request to begin a load; sampled only in IDLE or DONE.
REQ-006 SHALL have port WORD_COUNT  input  ADDR_WIDTH+1  number of words to load; sampled on accepted START.
REQ-007 SHALL have port BYTE_IN  input  8  program byte stream, little-endian within each word.
REQ-008 SHALL have port BYTE_VALID  input  1  BYTE_IN holds a valid byte.
REQ-009 SHALL have port BYTE_READY  output  1  loader can accept a byte this cycle.
REQ-010 SHALL have port ADDR_W  output  ADDR_WIDTH  instruction-memory write word address.
REQ-011 SHALL have port ENABLE_W  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 SHALL have port Q_W  output  SIZE  instruction-memory write data.
REQ-013 SHALL have port CPU_RESET_N  output  1  active-low reset to the core; low while not loaded or loading.
REQ-014 SHALL have port BUSY  output  1  load in progress.
REQ-015 SHALL have port DONE  output  1  last load completed; sticky until next accepted START or RESET.
REQ-016 SHALL have port ERROR  output  1  last START rejected; sticky until next accepted START or RESET.

Function
REQ-017 SHALL implement FSM states IDLE, RECV, WRITE, DONE.
REQ-018 In IDLE or DONE, START=1 with WORD_COUNT in 1..2**ADDR_WIDTH SHALL go to RECV next cycle with word index 0, byte index 0; DONE, ERROR cleared; BUSY=1; CPU_RESET_N=0.
REQ-019 START=1 with WORD_COUNT=0 SHALL go directly to DONE next cycle with no ENABLE_W pulse.
REQ-020 START=1 with WORD_COUNT > 2**ADDR_WIDTH SHALL set ERROR=1, perform no writes, and leave state, DONE and CPU_RESET_N unchanged.
REQ-021 START while in RECV or WRITE SHALL be ignored.
REQ-022 BYTE_READY SHALL be 1 exactly when in RECV; a byte is accepted on a cycle with BYTE_VALID=1 and BYTE_READY=1.
REQ-023 Accepted byte k (k=0..3) SHALL be placed in word bits [8k+7:8k]; byte index increments per accepted byte.
REQ-024 Acceptance of byte 3 SHALL move to WRITE next cycle; in WRITE, ENABLE_W=1 for exactly one cycle with ADDR_W = word index, Q_W = assembled word.
REQ-025 ENABLE_W SHALL be 0 in every state except WRITE; ADDR_W/Q_W hold last values otherwise.
REQ-026 From WRITE, if word index = WORD_COUNT-1, SHALL go to DONE; otherwise increment word index, reset byte index, return to RECV.
REQ-027 Minimum throughput SHALL be one word per 5 cycles (4 RECV + 1 WRITE); BYTE_VALID gaps stall RECV without losing data.
REQ-028 WORD_COUNT = 2**ADDR_WIDTH SHALL write addresses 0..2**ADDR_WIDTH-1 with no wrap or extra write.
REQ-029 In DONE, BUSY=0, DONE=1, CPU_RESET_N=1; state held until START or RESET.
REQ-030 CPU_RESET_N SHALL be a registered output, glitch-free, rising on the cycle DONE rises.

Reset
REQ-031 RESET=1 at a rising edge SHALL force IDLE, byte/word indices 0, and ADDR_W=0, ENABLE_W=0, Q_W=0, BYTE_READY=0, BUSY=0, DONE=0, ERROR=0, CPU_RESET_N=0 next cycle.
REQ-032 RESET SHALL take priority over START and byte acceptance; a reset mid-load SHALL abort with no further ENABLE_W pulse; already-written words are not undone.

Verification
REQ-033 Reset then START, WORD_COUNT=2, bytes 13 00 00 00 93 00 10 00 continuous -> ENABLE_W at ADDR_W=0 Q_W=0x00000013, then ADDR_W=1 Q_W=0x00100093; DONE, CPU_RESET_N=1 one cycle after second write; total 10 cycles from RECV entry.
REQ-034 Same load with BYTE_VALID low 3 cycles between every byte -> identical writes, no lost or duplicated bytes, BYTE_READY=0 during WRITE.
REQ-035 START with WORD_COUNT=0 -> DONE=1 next cycle, no ENABLE_W; START with WORD_COUNT=1025 (ADDR_WIDTH=10) -> ERROR=1, stays IDLE, CPU_RESET_N=0.
REQ-036 RESET asserted after 2 bytes of word 1 -> all outputs at reset values next cycle, no write to address 1; subsequent START reloads from address 0.
REQ-037 START pulsed in RECV -> ignored; START in DONE with WORD_COUNT=1 -> DONE=0, CPU_RESET_N=0, BUSY=1 next cycle, reload completes normally.
